// File: rtl/pattern_buffer_bank.sv
// pattern_buffer_bank: a bank of NUM_BUFS pattern buffers, each DEPTH x WIDTH.
// Buffers are loaded through a framed serial daisy chain (sin/sout/ssel/saddr).
// The pattern engine reads them through a registered port (bufselect/bufp -> pat_out).
// Optional feature macro: PATBUF_PARITY_EN adds a stored even-parity bit per word
// and a par_err output that is registered alongside pat_out.
//
// Serial frame protocol:
//   A frame opens on the first ssel=1 cycle after an ssel=0 cycle, and saddr is captured then.
//   Data arrives MSB-first, one bit per ssel=1 cycle, and every WIDTH bits form one word.
//   The frame closes on the first ssel=0 cycle.
//   load_done pulses on the cycle after a clean close.
//   load_err and load_ovf describe the last frame and hold until the next frame opens.
module pattern_buffer_bank #(
    parameter int NUM_BUFS = 8,
    parameter int DEPTH    = 27,
    parameter int WIDTH    = 8,
    parameter int BUF_AW   = 3,
    parameter int PTR_W    = 5
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              sin,
    input  logic              ssel,
    input  logic [BUF_AW-1:0] saddr,
    output logic              sout,
    input  logic [BUF_AW-1:0] bufselect,
    input  logic [PTR_W-1:0]  bufp,
    output logic [WIDTH-1:0]  pat_out,
`ifdef PATBUF_PARITY_EN
    output logic              par_err,
`endif
    output logic              load_done,
    output logic              load_err,
    output logic              load_ovf
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
`ifdef PATBUF_PARITY_EN
    localparam int MEM_W = WIDTH + 1;
`else
    localparam int MEM_W = WIDTH;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t              state;
    logic                ssel_d;
    logic [WIDTH-1:0]    shreg;
    logic [CNT_W-1:0]    bitcnt;
    logic [PTR_W-1:0]    wptr;
    logic [BUF_AW-1:0]   tgt;
    logic                wrote;

    logic [MEM_W-1:0]    mem [NUM_BUFS][DEPTH];

    logic                word_last;
    logic                wr_en;
    logic [WIDTH-1:0]    wr_word;
    logic [MEM_W-1:0]    rd_word;
    logic                rd_valid;
    logic                ptr_last;

    // The word completes on the cycle its final bit arrives, so that bit comes straight from sin.
    assign word_last = (bitcnt == CNT_W'(WIDTH - 1));
    assign wr_en     = (state == ST_SHIFT) && ssel && word_last;
    assign wr_word   = {shreg[WIDTH-2:0], sin};
    assign ptr_last  = (wptr == PTR_W'(DEPTH - 1));
    assign rd_word   = mem[bufselect][bufp];
    assign rd_valid  = (32'(bufselect) < NUM_BUFS) && (32'(bufp) < DEPTH);

    // Frame control, serial shifter, write pointer and load status flags.
    always_ff @(posedge sclk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ssel_d    <= 1'b1;
            shreg     <= '0;
            bitcnt    <= '0;
            wptr      <= '0;
            tgt       <= '0;
            wrote     <= 1'b0;
            sout      <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            load_ovf  <= 1'b0;
        end else begin
            ssel_d    <= ssel;
            load_done <= 1'b0;
            if (ssel) begin
                shreg <= {shreg[WIDTH-2:0], sin};
                sout  <= shreg[WIDTH-1];
            end
            case (state)
                ST_IDLE: begin
                    // ssel held high straight out of reset is not a frame: ssel_d resets to 1.
                    if (ssel && !ssel_d) begin
                        tgt      <= saddr;
                        wptr     <= '0;
                        bitcnt   <= CNT_W'(1);
                        wrote    <= 1'b0;
                        load_ovf <= 1'b0;
                        if (32'(saddr) >= NUM_BUFS) begin
                            state    <= ST_ABORT;
                            load_err <= 1'b1;
                        end else begin
                            state    <= ST_SHIFT;
                            load_err <= 1'b0;
                        end
                    end
                end
                ST_SHIFT, ST_ABORT: begin
                    if (ssel) begin
                        if (word_last) begin
                            bitcnt <= '0;
                            wptr   <= ptr_last ? '0 : wptr + 1'b1;
                            if (ptr_last) load_ovf <= 1'b1;
                            if (state == ST_SHIFT) wrote <= 1'b1;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                        if (bitcnt != '0) begin
                            load_err <= 1'b1;
                        end else if (wrote && !load_err) begin
                            load_done <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pattern memory write; its contents are deliberately left unreset.
    always_ff @(posedge sclk) begin
        if (wr_en) begin
`ifdef PATBUF_PARITY_EN
            mem[tgt][wptr] <= {^wr_word, wr_word};
`else
            mem[tgt][wptr] <= wr_word;
`endif
        end
    end

    // Registered read port; a same-cycle write to the same word returns the old data.
    always_ff @(posedge sclk) begin
        if (reset) begin
            pat_out <= '0;
`ifdef PATBUF_PARITY_EN
            par_err <= 1'b0;
`endif
        end else if (rd_valid) begin
            pat_out <= rd_word[WIDTH-1:0];
`ifdef PATBUF_PARITY_EN
            par_err <= rd_word[WIDTH] ^ (^rd_word[WIDTH-1:0]);
`endif
        end else begin
            pat_out <= '0;
`ifdef PATBUF_PARITY_EN
            par_err <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_pattern_buffer_bank.sv
// tb_pattern_buffer_bank: directed test of pattern_buffer_bank built with NUM_BUFS=6.
// The expected values below are worked out by hand from the frame contents.
module tb_pattern_buffer_bank;

    logic       sclk;
    logic       reset;
    logic       sin;
    logic       ssel;
    logic [2:0] saddr;
    logic       sout;
    logic [2:0] bufselect;
    logic [4:0] bufp;
    logic [7:0] pat_out;
    logic       load_done;
    logic       load_err;
    logic       load_ovf;
`ifdef PATBUF_PARITY_EN
    logic       par_err;
`endif

    int checks   = 0;
    int failures = 0;

    pattern_buffer_bank #(
        .NUM_BUFS(6), .DEPTH(27), .WIDTH(8), .BUF_AW(3), .PTR_W(5)
    ) dut (
        .sclk(sclk),
        .reset(reset),
        .sin(sin),
        .ssel(ssel),
        .saddr(saddr),
        .sout(sout),
        .bufselect(bufselect),
        .bufp(bufp),
        .pat_out(pat_out),
`ifdef PATBUF_PARITY_EN
        .par_err(par_err),
`endif
        .load_done(load_done),
        .load_err(load_err),
        .load_ovf(load_ovf)
    );

    // Clock.
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ssel = 1'b1;
        sin  = b;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic end_frame();
        ssel = 1'b0;
        sin  = 1'b0;
        tick();
    endtask

    task automatic read_chk(input string tag, input logic [2:0] sel, input logic [4:0] p,
                            input logic [7:0] exp);
        bufselect = sel;
        bufp      = p;
        tick();
        check_eq(tag, 32'(pat_out), 32'(exp));
`ifdef PATBUF_PARITY_EN
        check_eq({tag, "_par"}, 32'(par_err), 0);
`endif
    endtask

    logic       seen_done;
    logic [7:0] w;
    logic [15:0] pat;

    initial begin
        // Reset with ssel held high, then hold ssel high with no frame edge.
        reset = 1'b1; ssel = 1'b1; sin = 1'b0; saddr = 3'd0; bufselect = 3'd0; bufp = 5'd0;
        tick(); tick(); tick();
        check_eq("rst_pat_out", 32'(pat_out), 0);
        check_eq("rst_sout", 32'(sout), 0);
        check_eq("rst_done", 32'(load_done), 0);
        check_eq("rst_err", 32'(load_err), 0);
        check_eq("rst_ovf", 32'(load_ovf), 0);
        reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_bit(1'($urandom_range(0, 1)));
            seen_done = seen_done | load_done;
        end
        end_frame();
        seen_done = seen_done | load_done;
        check_eq("no_frame_done", 32'(seen_done), 0);
        check_eq("no_frame_err", 32'(load_err), 0);

        // Three clean words into buffer 2.
        saddr = 3'd2;
        send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hFF);
        end_frame();
        check_eq("b2_done", 32'(load_done), 1);
        check_eq("b2_err", 32'(load_err), 0);
        check_eq("b2_ovf", 32'(load_ovf), 0);
        tick();
        check_eq("b2_done_pulse", 32'(load_done), 0);
        read_chk("b2_w0", 3'd2, 5'd0, 8'hA5);
        read_chk("b2_w1", 3'd2, 5'd1, 8'h3C);
        read_chk("b2_w2", 3'd2, 5'd2, 8'hFF);

        // 28 words into buffer 1: words 1..27, then 0xE7 wraps onto word 0.
        saddr = 3'd1;
        for (int i = 0; i < 27; i++) begin
            w = 8'(i + 1);
            send_byte(w);
        end
        send_byte(8'hE7);
        end_frame();
        check_eq("ovf_flag", 32'(load_ovf), 1);
        check_eq("ovf_done", 32'(load_done), 1);
        check_eq("ovf_err", 32'(load_err), 0);
        read_chk("ovf_w0", 3'd1, 5'd0, 8'hE7);
        read_chk("ovf_w1", 3'd1, 5'd1, 8'h02);
        read_chk("ovf_w26", 3'd1, 5'd26, 8'h1B);

        // 13-bit frame into buffer 3: one word plus 5 stray bits.
        saddr = 3'd3;
        send_byte(8'h5A);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        end_frame();
        check_eq("part_err", 32'(load_err), 1);
        check_eq("part_done", 32'(load_done), 0);
        read_chk("part_w0", 3'd3, 5'd0, 8'h5A);

        // Frame to buffer 7, which does not exist: error from the first cycle, sout still echoes sin.
        saddr = 3'd7;
        pat = 16'h81C3;
        for (int k = 0; k < 16; k++) begin
            send_bit(pat[15-k]);
            if (k == 0) check_eq("abort_err_early", 32'(load_err), 1);
            if (k >= 8) check_eq("abort_sout", 32'(sout), 32'(pat[15-(k-8)]));
        end
        end_frame();
        check_eq("abort_err", 32'(load_err), 1);
        check_eq("abort_done", 32'(load_done), 0);
        read_chk("abort_b2_kept", 3'd2, 5'd0, 8'hA5);
        read_chk("oor_buf", 3'd7, 5'd0, 8'h00);
        read_chk("oor_ptr", 3'd2, 5'd27, 8'h00);

        // Read-before-write collision on buffer 0 word 4.
        saddr = 3'd0;
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        send_byte(8'h99);
        end_frame();
        check_eq("coll_setup_done", 32'(load_done), 1);
        bufselect = 3'd0;
        bufp      = 5'd4;
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        send_byte(8'h11);
        check_eq("coll_old", 32'(pat_out), 'h99);
        end_frame();
        check_eq("coll_new", 32'(pat_out), 'h11);
        check_eq("coll_done", 32'(load_done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
